tw4_cpu: RTL and testbench
==========================

// Module: tw4_cpu
// PURPOSE
//   4-bit accumulator CPU (TD4-class): registers A, B, output latch, 4-bit PC, carry flag.
//   Fetches one 8-bit instruction per clock from a 16-entry combinational program ROM
//   via addr/data, and executes it in the same cycle.
//   Drives a 4-bit LED output port and reads a 4-bit switch input port.
//   Sits in the system top next to its program memory, tw4_rom.
// PARAMETERS
//   none (widths fixed: data_t = 8 bits, addr_t = 4 bits)
// PORTS
//   clock  in   1  single system clock; all state updates on posedge
//   reset  in   1  synchronous, active-high reset
//   addr   out  4  instruction fetch address (addr_t) = PC
//   data   in   8  instruction word from ROM (data_t), valid combinationally for addr
//   in     in   4  input port, sampled by IN instructions at the clock edge
//   out    out  4  output port latch (LEDs)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset (posedge, reset=1): PC=0, A=0, B=0, out=0, carry=0. Reset overrides any instruction.
//   - addr = PC at all times (combinational). Single-cycle execution: 1 instruction per clock.
//   - Instruction fields: op = data[7:4], im = data[3:0].
//   - Datapath: result[4:0] = src + im, where src is one of A, B, in or 0 per op.
//   - Each op writes one destination with result[3:0].
//   - Opcodes (src -> dst):
//       0000 ADD A,Im : A+im    -> A      0101 ADD B,Im : B+im    -> B
//       0001 MOV A,B  : B+im    -> A      0110 IN B     : in+im   -> B
//       0010 IN A     : in+im   -> A      0111 MOV B,Im : 0+im    -> B
//       0011 MOV A,Im : 0+im    -> A      1001 OUT B    : B+im    -> out
//       0100 MOV B,A  : A+im    -> B      1011 OUT Im   : 0+im    -> out
//       1110 JNC Im   : PC <= im if carry==0, else PC+1
//       1111 JMP Im   : PC <= im
//   - Undefined ops (1000,1010,1100,1101): NOP; registers unchanged, PC+1.
//   - carry <= result[4] every non-reset cycle, for all ops.
//       JMP/JNC/MOV Im/OUT Im/NOP therefore clear carry.
//       JNC tests the carry left by the previous instruction.
//   - PC: +1 mod 16 for all non-jump ops (15 wraps to 0). Arithmetic is 4-bit, wraps.
//       Example: A=15, ADD A,1 -> A=0, carry=1.
//   - out holds its value until the next OUT instruction.
// STRUCTURE
//   - Shared package tw4_pkg: data_t (logic[7:0]), addr_t (logic[3:0]), opcode_t enum with the codes above.
//   - tw4_cpu: PC/A/B/out/carry registers, combinational decoder, 4-bit adder with carry-out.
//   - Sub-module tw4_rom (the "memory" block): combinational, 16x8.
//       ports addr (addr_t in), data (data_t out); data = rom[addr].
//   - Default tw4_rom program (LED counter):
//       0:0x01 ADD A,1   1:0x40 MOV B,A   2:0x90 OUT B   3:0xF0 JMP 0
//       4..15: 0x00
// TESTING
//   - Reset held 2 cycles -> addr=0, out=0, A=B=0, carry=0. Release: PC advances 0,1,2,3,0 with default ROM.
//   - Default program, 10 cycles after reset -> out changes 0->1 at cycle 3, 1->2 at cycle 7.
//       addr sequence 0,1,2,3,0,1,...
//   - ROM {MOV A,15; ADD A,1; JNC 0; OUT Im 5} -> A=0, carry=1, JNC falls through, out=5.
//       Same ROM with MOV A,14 -> JNC taken, PC=0.
//   - in=4'hA; ROM {IN B; OUT B} -> out=10.
//       ROM {IN A,3} with in=15 -> A=2, carry=1.
//   - PC wrap: ROM all 0x00 except rom[15]=0xB7 (OUT 7) -> out=7 at cycle 16, then PC=0.
//       Undefined op 0x8F -> no register change, PC+1, carry=0.
//   - Reset asserted mid-program (PC=2, out=3) -> next posedge all state 0; no half-executed instruction.

Source files
------------

// File: rtl/tw4_pkg.sv
// Shared types for the tw4 4-bit accumulator CPU and its program ROM.
package tw4_pkg;

  typedef logic [7:0] data_t;
  typedef logic [3:0] addr_t;

  // Instruction opcodes (data[7:4]); codes not listed here execute as NOP.
  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_t;

  // Adder source operand selection.
  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

  // Destination register for the adder result.
  typedef enum logic [1:0] {
    DST_A    = 2'd0,
    DST_B    = 2'd1,
    DST_OUT  = 2'd2,
    DST_NONE = 2'd3
  } dst_t;

  // Default program: LED counter (A++, B=A, out=B, loop).
  function automatic data_t default_program(input addr_t a);
    data_t d;
    case (a)
      4'd0:    d = 8'h01;
      4'd1:    d = 8'h40;
      4'd2:    d = 8'h90;
      4'd3:    d = 8'hF0;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tw4_rom.sv
// Combinational 16x8 program ROM holding the default LED-counter program.
module tw4_rom
  import tw4_pkg::*;
(
  input  addr_t addr,
  output data_t data
);

  assign data = default_program(addr);

endmodule

// File: rtl/tw4_cpu.sv
// TD4-class 4-bit accumulator CPU: one instruction fetched and executed per clock.
module tw4_cpu
  import tw4_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  output addr_t addr,
  input  data_t data,
  input  logic [3:0] in,
  output logic [3:0] out
);

  logic [3:0] r_pc;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_out;
  logic       r_carry;

  logic [3:0] w_op;
  logic [3:0] w_im;
  src_t       w_src;
  dst_t       w_dst;
  logic       w_jmp;
  logic       w_jnc;
  logic [3:0] w_src_val;
  logic [4:0] w_sum;
  logic [3:0] w_pc_next;

  assign w_op = data[7:4];
  assign w_im = data[3:0];
  assign addr = r_pc;
  assign out  = r_out;

  // Decode opcode into adder source, destination and jump kind.
  always_comb begin
    w_src = SRC_ZERO;
    w_dst = DST_NONE;
    w_jmp = 1'b0;
    w_jnc = 1'b0;
    case (w_op)
      OP_ADD_A:  begin w_src = SRC_A;    w_dst = DST_A;   end
      OP_MOV_AB: begin w_src = SRC_B;    w_dst = DST_A;   end
      OP_IN_A:   begin w_src = SRC_IN;   w_dst = DST_A;   end
      OP_MOV_AI: begin w_src = SRC_ZERO; w_dst = DST_A;   end
      OP_MOV_BA: begin w_src = SRC_A;    w_dst = DST_B;   end
      OP_ADD_B:  begin w_src = SRC_B;    w_dst = DST_B;   end
      OP_IN_B:   begin w_src = SRC_IN;   w_dst = DST_B;   end
      OP_MOV_BI: begin w_src = SRC_ZERO; w_dst = DST_B;   end
      OP_OUT_B:  begin w_src = SRC_B;    w_dst = DST_OUT; end
      OP_OUT_I:  begin w_src = SRC_ZERO; w_dst = DST_OUT; end
      OP_JNC:    begin w_src = SRC_ZERO; w_jnc = 1'b1;    end
      OP_JMP:    begin w_src = SRC_ZERO; w_jmp = 1'b1;    end
      default:   begin w_src = SRC_ZERO; w_dst = DST_NONE; end
    endcase
  end

  // Select the adder source operand.
  always_comb begin
    case (w_src)
      SRC_A:   w_src_val = r_a;
      SRC_B:   w_src_val = r_b;
      SRC_IN:  w_src_val = in;
      default: w_src_val = 4'd0;
    endcase
  end

  // 4-bit adder with carry-out; jumps and NOPs add to zero so carry clears.
  assign w_sum = {1'b0, w_src_val} + {1'b0, w_im};

  // Next PC: unconditional jump, jump on carry clear, or increment with wrap.
  always_comb begin
    if (w_jmp) begin
      w_pc_next = w_im;
    end else if (w_jnc && !r_carry) begin
      w_pc_next = w_im;
    end else begin
      w_pc_next = r_pc + 4'd1;
    end
  end

  // Architectural state update; reset wins over the instruction on the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= 4'd0;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_out   <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_carry <= w_sum[4];
      case (w_dst)
        DST_A:   r_a   <= w_sum[3:0];
        DST_B:   r_b   <= w_sum[3:0];
        DST_OUT: r_out <= w_sum[3:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tw4_cpu.sv
// Directed self-checking bench for tw4_cpu with default ROM or a bench-loaded program.
module tb_tw4_cpu;
  import tw4_pkg::*;

  logic       clock;
  logic       reset;
  addr_t      addr;
  data_t      data;
  data_t      w_rom_data;
  logic [3:0] in;
  logic [3:0] out;
  logic       use_def;
  data_t      prog [16];

  int total;
  int bad;

  tw4_cpu dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .data  (data),
    .in    (in),
    .out   (out)
  );

  tw4_rom u_rom (
    .addr (addr),
    .data (w_rom_data)
  );

  assign data = use_def ? w_rom_data : prog[addr];

  // Free-running clock, posedge at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  // One-cycle synchronous reset with whatever program is loaded.
  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    in      = 4'h0;
    use_def = 1'b1;
    clear_prog();

    // Reset held 2 cycles
    step(2);
    chk("rst_addr",  {4'h0, addr}, 8'h00);
    chk("rst_out",   {4'h0, out}, 8'h00);
    chk("rst_a",     {4'h0, dut.r_a}, 8'h00);
    chk("rst_b",     {4'h0, dut.r_b}, 8'h00);
    chk("rst_carry", {7'h00, dut.r_carry}, 8'h00);
    reset = 1'b0;

    // Default LED counter: addr 1,2,3,0,1,2,3; out 0->1 at cycle 3, 1->2 at cycle 7
    step(1); chk("def_c1_addr", {4'h0, addr}, 8'h01);
    step(1); chk("def_c2_addr", {4'h0, addr}, 8'h02);
             chk("def_c2_out",  {4'h0, out},  8'h00);
    step(1); chk("def_c3_addr", {4'h0, addr}, 8'h03);
             chk("def_c3_out",  {4'h0, out},  8'h01);
    step(1); chk("def_c4_addr", {4'h0, addr}, 8'h00);
    step(1); chk("def_c5_addr", {4'h0, addr}, 8'h01);
             chk("def_c5_a",    {4'h0, dut.r_a}, 8'h02);
    step(1); chk("def_c6_out",  {4'h0, out},  8'h01);
    step(1); chk("def_c7_out",  {4'h0, out},  8'h02);
             chk("def_c7_addr", {4'h0, addr}, 8'h03);

    // MOV A,15; ADD A,1; JNC 0; OUT 5 -> carry set, JNC falls through
    use_def = 1'b0;
    clear_prog();
    prog[0] = 8'h3F; prog[1] = 8'h01; prog[2] = 8'hE0; prog[3] = 8'hB5;
    do_reset();
    step(2);
    chk("ovf_a",     {4'h0, dut.r_a}, 8'h00);
    chk("ovf_carry", {7'h00, dut.r_carry}, 8'h01);
    step(1);
    chk("jnc_fall_addr", {4'h0, addr}, 8'h03);
    chk("jnc_carry_clr", {7'h00, dut.r_carry}, 8'h00);
    step(1);
    chk("outim_out", {4'h0, out}, 8'h05);

    // Same with MOV A,14 -> no carry, JNC taken back to 0
    prog[0] = 8'h3E;
    do_reset();
    step(2);
    chk("nc_a",     {4'h0, dut.r_a}, 8'h0F);
    chk("nc_carry", {7'h00, dut.r_carry}, 8'h00);
    step(1);
    chk("jnc_taken_addr", {4'h0, addr}, 8'h00);
    chk("jnc_taken_out",  {4'h0, out},  8'h00);

    // in=A; IN B; OUT B -> out=10
    clear_prog();
    prog[0] = 8'h60; prog[1] = 8'h90;
    in = 4'hA;
    do_reset();
    step(2);
    chk("inb_b",   {4'h0, dut.r_b}, 8'h0A);
    chk("inb_out", {4'h0, out}, 8'h0A);

    // IN A,3 with in=15 -> A=2, carry=1
    clear_prog();
    prog[0] = 8'h23;
    in = 4'hF;
    do_reset();
    step(1);
    chk("ina_a",     {4'h0, dut.r_a}, 8'h02);
    chk("ina_carry", {7'h00, dut.r_carry}, 8'h01);
    in = 4'h0;

    // PC wrap: only rom[15]=OUT 7
    clear_prog();
    prog[15] = 8'hB7;
    do_reset();
    step(15);
    chk("wrap_c15_addr", {4'h0, addr}, 8'h0F);
    chk("wrap_c15_out",  {4'h0, out},  8'h00);
    step(1);
    chk("wrap_c16_out",  {4'h0, out},  8'h07);
    chk("wrap_c16_addr", {4'h0, addr}, 8'h00);

    // Undefined op 0x8F after carry set: nothing changes, carry cleared
    clear_prog();
    prog[0] = 8'h73; prog[1] = 8'h3F; prog[2] = 8'h01; prog[3] = 8'h8F;
    do_reset();
    step(3);
    chk("pre_nop_carry", {7'h00, dut.r_carry}, 8'h01);
    step(1);
    chk("nop_addr",  {4'h0, addr}, 8'h04);
    chk("nop_a",     {4'h0, dut.r_a}, 8'h00);
    chk("nop_b",     {4'h0, dut.r_b}, 8'h03);
    chk("nop_out",   {4'h0, out}, 8'h00);
    chk("nop_carry", {7'h00, dut.r_carry}, 8'h00);

    // Mid-program reset at PC=2, out=3: ADD A,1 must not execute
    clear_prog();
    prog[0] = 8'h33; prog[1] = 8'hB3; prog[2] = 8'h01;
    do_reset();
    step(2);
    chk("mid_pre_addr", {4'h0, addr}, 8'h02);
    chk("mid_pre_out",  {4'h0, out},  8'h03);
    do_reset();
    chk("mid_addr",  {4'h0, addr}, 8'h00);
    chk("mid_out",   {4'h0, out},  8'h00);
    chk("mid_a",     {4'h0, dut.r_a}, 8'h00);
    chk("mid_b",     {4'h0, dut.r_b}, 8'h00);
    chk("mid_carry", {7'h00, dut.r_carry}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
